acc_sequencer: RTL and testbench
================================

Name: acc_sequencer

Overview:
- Controls the 16-entry, 16-lane x 20-bit partial-sum accumulator.
- Generates write and accumulate controls while systolic-array row results stream in over a programmed number of K-tile passes.
- After the last pass, reads every row out to the unified-buffer writer under valid/ready flow control.
- Does not touch data: array results go straight to the accumulator data-in, and accumulator data-out goes straight to the consumer.

Parameters:
ADDR_W, 4, accumulator address width (depth = 2**ADDR_W = 16)
PASS_W, 8, width of pass counter (max 256 K-tile passes)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; latches cfg_rows_m1/cfg_passes_m1 and begins a job when idle
cfg_rows_m1  input  ADDR_W  rows per pass minus 1 (0..15)
cfg_passes_m1  input  PASS_W  passes minus 1
psum_valid  input  1  array presents one row of 16 partial sums this cycle
acc_wea  output  1  accumulator write enable
acc_acc_en  output  1  accumulator add-vs-overwrite select
acc_addra  output  ADDR_W  accumulator write address
acc_enb  output  1  accumulator read enable
acc_addrb  output  ADDR_W  accumulator read address
out_valid  output  1  accumulator data-out holds a valid row for the consumer
out_last  output  1  qualifies out_valid: this is the final row of the job
out_ready  input  1  consumer accepts the row when out_valid && out_ready
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse when the job completes

Behaviour:
- Reset (async, reset_n=0): state=IDLE. All pointers, counters and outputs are 0: busy, done, out_valid, out_last, acc_enb, acc_wea, acc_acc_en, acc_addra, acc_addrb.
- States:
  - IDLE: start=1 latches cfg into rows_m1/passes_m1, clears wr_ptr and pass_cnt, and moves to ACCUM next cycle. busy=1 from that edge.
  - ACCUM: combinational acc_wea = psum_valid; acc_addra = wr_ptr; acc_acc_en = (pass_cnt != 0).
    - Pass 0 therefore overwrites stale contents; later passes add lane-wise.
    - The accumulator samples these on the following falling edge, so they must be glitch-free, registered-source-plus-AND only.
    - On each psum_valid: if wr_ptr == rows_m1, wr_ptr->0 and pass_cnt+1; else wr_ptr+1.
    - When psum_valid occurs with wr_ptr==rows_m1 and pass_cnt==passes_m1: go to DRAIN, rd_ptr=0.
    - psum_valid gaps (low cycles) stall with no writes.
  - DRAIN:
    - Issue condition: issue = !rd_done && (!out_valid || out_ready).
    - acc_enb = issue (combinational); acc_addrb = rd_ptr.
    - Accumulator data-out updates on the falling edge, so the row is stable by the next rising edge.
    - out_valid is a register: set on issue, cleared on a handshake with no new issue. Data-out only changes on acc_enb, so holding enb low holds the data; no skid buffer is needed.
    - rd_ptr increments per issue; after issuing rd_ptr==rows_m1, rd_done=1.
    - out_last is registered with the row read at rows_m1.
    - A handshake with out_last=1 moves to DONE.
  - DONE: done=1 for one cycle, busy=0 and state=IDLE next cycle.
- Throughput and latency:
  - Drain sustains 1 row/cycle with out_ready held high.
  - First out_valid appears 1 cycle after entering DRAIN.
  - Total drain is rows_m1+2 cycles from DRAIN entry to DONE.
- Boundaries:
  - start while busy is ignored; cfg is not re-latched.
  - psum_valid in IDLE, DRAIN or DONE is ignored: acc_wea=0.
  - rows_m1=0 and passes_m1=0 is legal: one write, one read, done.
  - wr_ptr wraps at rows_m1, never at 2**ADDR_W, unless rows_m1=15.
  - acc_wea and acc_enb are never both high; phases are exclusive.
  - out_ready low throughout DRAIN: out_valid, out_last and data hold, rd_ptr frozen.
  - reset_n asserted mid-ACCUM or mid-DRAIN: immediate return to IDLE with all outputs 0; no done pulse. Accumulator contents are don't-care; the next job's pass 0 overwrites them.

Test Plan:
- Reset, then start with rows_m1=3, passes_m1=0, and 4 consecutive psum_valid -> acc_wea on 4 cycles, addra 0,1,2,3, acc_acc_en=0 throughout; then 4 rows out, addrb 0..3, out_last on the 4th, done pulse 1 cycle later.
- rows_m1=1, passes_m1=2, all lanes of dina=5 each beat -> acc_acc_en 0,0,1,1,1,1; drained lanes all equal 15; lane -3 x3 passes drains as 20'hFFFF7.
- Drain with out_ready pattern 1,0,0,1,1 -> out_valid held across the low cycles with data and addrb unchanged; acc_enb low while out_valid && !out_ready; no row lost or duplicated.
- psum_valid toggling 1,0,1,0 in ACCUM plus psum_valid pulses during DRAIN -> no writes on gap cycles or in DRAIN; wr_ptr advances only on valid.
- reset_n pulsed low mid-ACCUM (after 2 of 4 rows) -> all outputs 0 asynchronously, state IDLE, no done; a fresh job then completes normally with acc_acc_en=0 on pass 0.
- start asserted while busy with different cfg -> ignored; original job row count drained; rows_m1=0, passes_m1=0 job yields exactly one write, one read, one out_last.

Source files
------------

// File: rtl/acc_sequencer.sv
// -----------------------------------------------------------------------------
// acc_sequencer
//   Control sequencer for the 16-entry x 16-lane x 20-bit partial-sum
//   accumulator. While systolic-array rows stream in over a programmed number
//   of K-tile passes it produces the accumulator write/accumulate controls.
//   After the last pass it reads each row out to the unified-buffer writer
//   under valid/ready flow control. No data passes through this block.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   start                 one-cycle job start pulse (only honoured when idle)
//   cfg_rows_m1           rows per pass minus 1
//   cfg_passes_m1         K-tile passes minus 1
//   psum_valid            one array row is presented this cycle
//   acc_wea/acc_acc_en    accumulator write enable / add-vs-overwrite
//   acc_addra             accumulator write address
//   acc_enb/acc_addrb     accumulator read enable / read address
//   out_valid/out_last    a row is available for the consumer / final row
//   out_ready             consumer accepts the row
//   busy/done             job in flight / one-cycle completion pulse
// -----------------------------------------------------------------------------
module acc_sequencer #(
  parameter int ADDR_W = 4,
  parameter int PASS_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_rows_m1,
  input  logic [PASS_W-1:0] cfg_passes_m1,
  input  logic              psum_valid,
  output logic              acc_wea,
  output logic              acc_acc_en,
  output logic [ADDR_W-1:0] acc_addra,
  output logic              acc_enb,
  output logic [ADDR_W-1:0] acc_addrb,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e            state_q,     state_d;
  logic [ADDR_W-1:0] rows_m1_q,   rows_m1_d;
  logic [PASS_W-1:0] passes_m1_q, passes_m1_d;
  logic [ADDR_W-1:0] wr_ptr_q,    wr_ptr_d;
  logic [PASS_W-1:0] pass_cnt_q,  pass_cnt_d;
  logic [ADDR_W-1:0] rd_ptr_q,    rd_ptr_d;
  logic              rd_done_q,   rd_done_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q,  out_last_d;
  logic              busy_q,      busy_d;
  logic              done_q,      done_d;
  // Phase flags and the pass-nonzero flag are kept as flops so that the
  // accumulator strobes are a single AND of a flop with an input, which keeps
  // them glitch-free ahead of the falling-edge sampling in the accumulator.
  logic              accum_q,     accum_d;
  logic              drain_q,     drain_d;
  logic              pass_nz_q,   pass_nz_d;

  logic              write_s;
  logic              issue_s;
  logic              hs_s;

  // Strobes derived from registered phase flags and live handshake inputs.
  always_comb begin
    write_s = accum_q & psum_valid;
    hs_s    = out_valid_q & out_ready;
    issue_s = drain_q & ~rd_done_q & (~out_valid_q | out_ready);
  end

  // Next-state and next-register computation for the job sequencer.
  always_comb begin
    state_d     = state_q;
    rows_m1_d   = rows_m1_q;
    passes_m1_d = passes_m1_q;
    wr_ptr_d    = wr_ptr_q;
    pass_cnt_d  = pass_cnt_q;
    rd_ptr_d    = rd_ptr_q;
    rd_done_d   = rd_done_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          rows_m1_d   = cfg_rows_m1;
          passes_m1_d = cfg_passes_m1;
          wr_ptr_d    = {ADDR_W{1'b0}};
          pass_cnt_d  = {PASS_W{1'b0}};
          rd_ptr_d    = {ADDR_W{1'b0}};
          rd_done_d   = 1'b0;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          busy_d      = 1'b1;
          state_d     = S_ACCUM;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_ACCUM: begin
        if (write_s) begin
          if (wr_ptr_q == rows_m1_q) begin
            // Row wrap closes a pass; the final pass hands over to the drain.
            wr_ptr_d   = {ADDR_W{1'b0}};
            pass_cnt_d = pass_cnt_q + PASS_W'(1);
            if (pass_cnt_q == passes_m1_q) begin
              rd_ptr_d  = {ADDR_W{1'b0}};
              rd_done_d = 1'b0;
              state_d   = S_DRAIN;
            end else begin
              state_d = S_ACCUM;
            end
          end else begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          end
        end else begin
          state_d = S_ACCUM;
        end
      end

      S_DRAIN: begin
        // A read is issued only when the output slot is free or being freed,
        // so the accumulator data-out itself acts as the single output stage.
        if (issue_s) begin
          rd_ptr_d    = rd_ptr_q + ADDR_W'(1);
          out_valid_d = 1'b1;
          out_last_d  = (rd_ptr_q == rows_m1_q);
          rd_done_d   = (rd_ptr_q == rows_m1_q);
        end else if (hs_s) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end else begin
          out_valid_d = out_valid_q;
        end
        if (hs_s && out_last_q) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end

      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    accum_d   = (state_d == S_ACCUM);
    drain_d   = (state_d == S_DRAIN);
    pass_nz_d = (pass_cnt_d != {PASS_W{1'b0}});
  end

  // State and datapath-control registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      rows_m1_q   <= {ADDR_W{1'b0}};
      passes_m1_q <= {PASS_W{1'b0}};
      wr_ptr_q    <= {ADDR_W{1'b0}};
      pass_cnt_q  <= {PASS_W{1'b0}};
      rd_ptr_q    <= {ADDR_W{1'b0}};
      rd_done_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      accum_q     <= 1'b0;
      drain_q     <= 1'b0;
      pass_nz_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rows_m1_q   <= rows_m1_d;
      passes_m1_q <= passes_m1_d;
      wr_ptr_q    <= wr_ptr_d;
      pass_cnt_q  <= pass_cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_done_q   <= rd_done_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      accum_q     <= accum_d;
      drain_q     <= drain_d;
      pass_nz_q   <= pass_nz_d;
    end
  end

  // Output mapping; pass 0 overwrites stale entries, later passes add.
  always_comb begin
    acc_wea    = write_s;
    acc_acc_en = accum_q & pass_nz_q;
    acc_addra  = wr_ptr_q;
    acc_enb    = issue_s;
    acc_addrb  = rd_ptr_q;
    out_valid  = out_valid_q;
    out_last   = out_last_q;
    busy       = busy_q;
    done       = done_q;
  end

endmodule

// File: tb/tb_acc_sequencer.sv
module tb_acc_sequencer;

  localparam int ADDR_W = 4;
  localparam int PASS_W = 8;

  typedef logic [15:0][19:0] row_t;
  typedef struct {
    row_t data;
    logic last;
  } exp_row_t;
  typedef struct {
    logic [3:0] addr;
    logic       en;
  } exp_wr_t;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] cfg_rows_m1 = '0;
  logic [PASS_W-1:0] cfg_passes_m1 = '0;
  logic              psum_valid = 1'b0;
  logic              acc_wea, acc_acc_en, acc_enb;
  logic [ADDR_W-1:0] acc_addra, acc_addrb;
  logic              out_valid, out_last;
  logic              out_ready = 1'b0;
  logic              busy, done;

  row_t psum = '0;          // array row presented with psum_valid
  row_t acc_mem [16];       // behavioural accumulator RAM
  row_t acc_dout = '0;      // accumulator read port output
  row_t ref_mem [16];       // reference sums per row

  exp_row_t exp_q[$];
  exp_wr_t  wr_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_hs_cyc = -10;
  bit pending_done = 1'b0;

  acc_sequencer #(.ADDR_W(ADDR_W), .PASS_W(PASS_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .cfg_rows_m1(cfg_rows_m1), .cfg_passes_m1(cfg_passes_m1),
    .psum_valid(psum_valid),
    .acc_wea(acc_wea), .acc_acc_en(acc_acc_en), .acc_addra(acc_addra),
    .acc_enb(acc_enb), .acc_addrb(acc_addrb),
    .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic row_t gen_row(input int mode);
    row_t r;
    for (int l = 0; l < 16; l++) begin
      if (mode == 1) r[l] = (l < 8) ? 20'd5 : 20'hFFFFD;
      else           r[l] = 20'($urandom);
    end
    return r;
  endfunction

  // Monitor: scoreboard pops, protocol checks and the accumulator RAM model.
  initial begin
    exp_row_t e;
    exp_wr_t  w;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (acc_wea || acc_enb) chk("wea_enb_exclusive", 320'(acc_wea & acc_enb), 320'd0);
        if (out_valid && !out_ready) chk("enb_low_while_stalled", 320'(acc_enb), 320'd0);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_row", 320'(acc_addrb), 320'hDEAD);
          end else begin
            e = exp_q.pop_front();
            chk("row_data", acc_dout, e.data);
            chk("row_last", 320'(out_last), 320'(e.last));
            if (out_last) begin
              pending_done = 1'b1;
              last_hs_cyc  = cyc;
            end
          end
        end
        if (done) begin
          chk("done_expected", 320'(pending_done), 320'd1);
          chk("done_latency", 320'(cyc), 320'(last_hs_cyc + 1));
          pending_done = 1'b0;
        end
        if (acc_wea) begin
          if (wr_q.size() == 0) begin
            chk("unexpected_write", 320'(acc_addra), 320'hDEAD);
          end else begin
            w = wr_q.pop_front();
            chk("write_addr", 320'(acc_addra), 320'(w.addr));
            chk("write_acc_en", 320'(acc_acc_en), 320'(w.en));
          end
          for (int l = 0; l < 16; l++)
            acc_mem[acc_addra][l] = acc_acc_en ? acc_mem[acc_addra][l] + psum[l] : psum[l];
        end
        if (acc_enb) acc_dout = acc_mem[acc_addrb];
      end
    end
  end

  // gap_pct < 0 means strictly alternating valid/gap; ready_mode 0=always,
  // 1=random, 2=repeating 1,0,0,1,1.
  task automatic run_job(input int rows_m1, input int passes_m1, input int mode,
                         input int gap_pct, input int ready_mode, input bit busy_start);
    int   total, k, t, n;
    bit   beat;
    row_t d;
    exp_row_t e;
    exp_wr_t  w;
    total = (rows_m1 + 1) * (passes_m1 + 1);
    @(posedge clk); #1;
    start = 1'b1;
    cfg_rows_m1 = ADDR_W'(rows_m1);
    cfg_passes_m1 = PASS_W'(passes_m1);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", 320'(busy), 320'd1);
    k = 0;
    n = 0;
    while (k < total) begin
      start = 1'b0;
      if (gap_pct < 0) beat = (n % 2 == 0);
      else             beat = ($urandom_range(99) >= gap_pct);
      if (beat) begin
        d = gen_row(mode);
        psum = d;
        psum_valid = 1'b1;
        w.addr = 4'(k % (rows_m1 + 1));
        w.en   = (k / (rows_m1 + 1)) != 0;
        wr_q.push_back(w);
        for (int l = 0; l < 16; l++)
          ref_mem[w.addr][l] = w.en ? ref_mem[w.addr][l] + d[l] : d[l];
        k++;
      end else begin
        psum_valid = 1'b0;
        psum = gen_row(0);
        if (busy_start) begin
          start = 1'b1;
          cfg_rows_m1 = ADDR_W'($urandom);
          cfg_passes_m1 = PASS_W'($urandom);
        end
      end
      n++;
      @(posedge clk); #1;
    end
    for (int r = 0; r <= rows_m1; r++) begin
      e.data = ref_mem[r];
      e.last = (r == rows_m1);
      exp_q.push_back(e);
    end
    for (t = 0; t < 3000; t++) begin
      psum_valid = 1'(($urandom % 2));
      psum = gen_row(0);
      start = busy_start && (t == 1);
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'(($urandom % 2));
        default: out_ready = (t % 5 == 0) || (t % 5 >= 3);
      endcase
      @(posedge clk); #1;
      if (done) break;
    end
    if (t >= 3000) chk("done_timeout", 320'(t), 320'd0);
    start = 1'b0;
    psum_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("busy_after_done", 320'(busy), 320'd0);
    chk("done_one_cycle", 320'(done), 320'd0);
    chk("rows_all_drained", 320'(exp_q.size()), 320'd0);
    chk("writes_all_seen", 320'(wr_q.size()), 320'd0);
    exp_q.delete();
    wr_q.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},      320'(busy), 320'd0);
    chk({tag, "_done"},      320'(done), 320'd0);
    chk({tag, "_out_valid"}, 320'(out_valid), 320'd0);
    chk({tag, "_out_last"},  320'(out_last), 320'd0);
    chk({tag, "_acc_enb"},   320'(acc_enb), 320'd0);
    chk({tag, "_acc_wea"},   320'(acc_wea), 320'd0);
    chk({tag, "_acc_en"},    320'(acc_acc_en), 320'd0);
    chk({tag, "_addra"},     320'(acc_addra), 320'd0);
    chk({tag, "_addrb"},     320'(acc_addrb), 320'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      acc_mem[i] = '0;
      ref_mem[i] = '0;
    end
    reset_n = 1'b0;
    #12;
    chk_all_zero("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;

    run_job(3, 0, 0, 0, 0, 1'b0);
    run_job(1, 2, 1, 0, 0, 1'b0);
    run_job(4, 1, 0, 0, 2, 1'b0);
    run_job(3, 1, 0, -1, 1, 1'b0);

    // Abort an accumulation after two of four rows.
    @(posedge clk); #1;
    start = 1'b1; cfg_rows_m1 = 4'd3; cfg_passes_m1 = 8'd0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      psum = gen_row(0);
      psum_valid = 1'b1;
      wr_q.push_back('{addr: 4'(b), en: 1'b0});
      @(posedge clk); #1;
    end
    psum_valid = 1'b1;
    #3;
    reset_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    psum_valid = 1'b0;
    chk("midreset_writes_seen", 320'(wr_q.size()), 320'd0);
    wr_q.delete();
    exp_q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("midreset_idle_busy", 320'(busy), 320'd0);
    chk("midreset_no_done", 320'(done), 320'd0);
    run_job(3, 0, 0, 0, 0, 1'b0);

    run_job(5, 1, 0, 30, 1, 1'b1);
    run_job(0, 0, 0, 0, 0, 1'b0);
    run_job(15, 1, 0, 10, 0, 1'b0);
    for (int j = 0; j < 6; j++)
      run_job(int'($urandom_range(15)), int'($urandom_range(3)), 0, 30, 1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
